// File: rtl/trap_controller.sv
// Machine-mode trap unit: decodes SYSTEM instructions and the external interrupt at commit,
// owns mstatus.MIE/MPIE, mtvec, mepc and mcause, and issues a one-cycle redirect to fetch.
module trap_controller #(
   parameter int unsigned      XLEN      = 32,
   parameter logic [XLEN-1:0]  MTVEC_RST = '0,
   parameter bit               IRQ_EN    = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic             i_exception,
   input  logic [2:0]       i_funct3,
   input  logic [11:0]      i_funct12,
   input  logic [XLEN-1:0]  i_pc,
   input  logic             i_irq,
   input  logic             i_csr_we,
   input  logic [11:0]      i_csr_addr,
   input  logic [XLEN-1:0]  i_csr_wdata,
   output logic [XLEN-1:0]  o_csr_rdata,
   output logic             o_ecall,
   output logic             o_mret,
   output logic             o_kill,
   output logic             o_redirect,
   output logic [XLEN-1:0]  o_redirect_pc,
   output logic             o_busy
);

   typedef enum logic {IDLE, REDIR} state_t;

   state_t          state;
   logic            mie;
   logic            mpie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;

   logic            dec_en;
   logic            f3_sys;
   logic            is_ecall;
   logic            is_ebreak;
   logic            is_mret;
   logic            is_illegal;
   logic            irq_take;
   logic            trap;
   logic            csr_wr_ok;
   logic [XLEN-1:0] trap_cause;

   always_comb begin
      dec_en     = i_valid && i_exception && (state == IDLE) && !i_rst;
      f3_sys     = (i_funct3 == 3'b000);
      is_ecall   = dec_en && f3_sys && (i_funct12 == 12'h000);
      is_ebreak  = dec_en && f3_sys && (i_funct12 == 12'h001);
      is_mret    = dec_en && f3_sys && (i_funct12 == 12'h302);
      is_illegal = dec_en && ((f3_sys && (i_funct12 != 12'h000) && (i_funct12 != 12'h001)
                                      && (i_funct12 != 12'h302))
                              || (i_funct3 == 3'b100));
      // Synchronous events (including mret) always pre-empt the interrupt.
      irq_take   = IRQ_EN && i_irq && mie && i_valid && (state == IDLE) && !i_rst
                   && !(is_ecall || is_ebreak || is_illegal || is_mret);
      trap       = is_ecall || is_ebreak || is_illegal || irq_take;
      o_kill     = trap || is_mret;
      o_ecall    = is_ecall;
      o_mret     = is_mret;
      csr_wr_ok  = i_csr_we && (state == IDLE) && !o_kill;

      if (irq_take)       trap_cause = {1'b1, (XLEN-1)'(11)};
      else if (is_ecall)  trap_cause = XLEN'(11);
      else if (is_ebreak) trap_cause = XLEN'(3);
      else                trap_cause = XLEN'(2);
   end

   always_comb begin
      o_csr_rdata = '0;
      case (i_csr_addr)
         12'h300: begin
            o_csr_rdata[12:11] = 2'b11;
            o_csr_rdata[7]     = mpie;
            o_csr_rdata[3]     = mie;
         end
         12'h305: o_csr_rdata = mtvec;
         12'h341: o_csr_rdata = mepc;
         12'h342: o_csr_rdata = mcause;
         default: o_csr_rdata = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= IDLE;
         o_redirect    <= 1'b0;
         o_busy        <= 1'b0;
         o_redirect_pc <= '0;
         mie           <= 1'b0;
         mpie          <= 1'b0;
         mepc          <= '0;
         mcause        <= '0;
         mtvec         <= {MTVEC_RST[XLEN-1:2], 2'b00};
      end else begin
         case (state)
            IDLE: begin
               if (trap) begin
                  mepc          <= {i_pc[XLEN-1:2], 2'b00};
                  mpie          <= mie;
                  mie           <= 1'b0;
                  mcause        <= trap_cause;
                  o_redirect_pc <= {mtvec[XLEN-1:2], 2'b00};
                  state         <= REDIR;
                  o_redirect    <= 1'b1;
                  o_busy        <= 1'b1;
               end else if (is_mret) begin
                  mie           <= mpie;
                  mpie          <= 1'b1;
                  o_redirect_pc <= mepc;
                  state         <= REDIR;
                  o_redirect    <= 1'b1;
                  o_busy        <= 1'b1;
               end else if (csr_wr_ok) begin
                  case (i_csr_addr)
                     12'h300: begin
                        mie  <= i_csr_wdata[3];
                        mpie <= i_csr_wdata[7];
                     end
                     12'h305: mtvec  <= {i_csr_wdata[XLEN-1:2], 2'b00};
                     12'h341: mepc   <= {i_csr_wdata[XLEN-1:2], 2'b00};
                     12'h342: mcause <= i_csr_wdata;
                     default: ;
                  endcase
               end
            end
            REDIR: begin
               state      <= IDLE;
               o_redirect <= 1'b0;
               o_busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: XLEN=32 and XLEN=64 instances share stimulus and are checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_trap_controller;

   localparam int K_NONE = 0, K_ECALL = 1, K_EBREAK = 2, K_ILL = 3, K_MRET = 4, K_IRQ = 5;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, valid = 1'b0, exc = 1'b0, irq = 1'b0, we = 1'b0;
   logic [2:0]  f3 = '0;
   logic [11:0] f12 = '0, addr = '0;
   logic [63:0] pc = '0, wdata = '0;

   logic [31:0] a_rdata, a_rpc;
   logic        a_ecall, a_mret, a_kill, a_redir, a_busy;
   logic [63:0] b_rdata, b_rpc;
   logic        b_ecall, b_mret, b_kill, b_redir, b_busy;

   int tests = 0;
   int fails = 0;
   bit started = 1'b0;

   trap_controller #(.XLEN(32), .MTVEC_RST(32'h80), .IRQ_EN(1'b1)) dut32 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_exception(exc), .i_funct3(f3),
      .i_funct12(f12), .i_pc(pc[31:0]), .i_irq(irq), .i_csr_we(we), .i_csr_addr(addr),
      .i_csr_wdata(wdata[31:0]), .o_csr_rdata(a_rdata), .o_ecall(a_ecall), .o_mret(a_mret),
      .o_kill(a_kill), .o_redirect(a_redir), .o_redirect_pc(a_rpc), .o_busy(a_busy));

   trap_controller #(.XLEN(64), .MTVEC_RST(64'h1003), .IRQ_EN(1'b1)) dut64 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_exception(exc), .i_funct3(f3),
      .i_funct12(f12), .i_pc(pc), .i_irq(irq), .i_csr_we(we), .i_csr_addr(addr),
      .i_csr_wdata(wdata), .o_csr_rdata(b_rdata), .o_ecall(b_ecall), .o_mret(b_mret),
      .o_kill(b_kill), .o_redirect(b_redir), .o_redirect_pc(b_rpc), .o_busy(b_busy));

   // Architectural model, index 0 = XLEN 32, index 1 = XLEN 64
   logic        m_mie [2];
   logic        m_mpie[2];
   logic        m_busy[2];
   logic [63:0] m_mepc[2], m_mtvec[2], m_mcause[2], m_target[2];

   function automatic logic [63:0] msk(int k);
      return (k == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic int classify(int k);
      if (rst || m_busy[k] || !valid) return K_NONE;
      if (exc && f3 == 3'd0) begin
         if (f12 == 12'h000) return K_ECALL;
         if (f12 == 12'h001) return K_EBREAK;
         if (f12 == 12'h302) return K_MRET;
         return K_ILL;
      end
      if (exc && f3 == 3'd4) return K_ILL;
      if (irq && m_mie[k]) return K_IRQ;
      return K_NONE;
   endfunction

   function automatic logic [63:0] csr_read(int k);
      case (addr)
         12'h300: return 64'h1800 | (64'(m_mpie[k]) << 7) | (64'(m_mie[k]) << 3);
         12'h305: return m_mtvec[k];
         12'h341: return m_mepc[k];
         12'h342: return m_mcause[k];
         default: return 64'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int kind;
         kind = classify(k);
         if (rst) begin
            m_mie[k] = 1'b0; m_mpie[k] = 1'b0; m_busy[k] = 1'b0;
            m_mepc[k] = '0; m_mcause[k] = '0; m_target[k] = '0;
            m_mtvec[k] = (k == 0) ? 64'h80 : 64'h1000;
            started = 1'b1;
         end else if (m_busy[k]) begin
            m_busy[k] = 1'b0;
         end else if (kind == K_MRET) begin
            m_target[k] = m_mepc[k];
            m_mie[k] = m_mpie[k];
            m_mpie[k] = 1'b1;
            m_busy[k] = 1'b1;
         end else if (kind != K_NONE) begin
            m_mepc[k] = pc & ~64'h3 & msk(k);
            m_mpie[k] = m_mie[k];
            m_mie[k] = 1'b0;
            m_target[k] = m_mtvec[k];
            m_busy[k] = 1'b1;
            case (kind)
               K_ECALL:  m_mcause[k] = 64'd11;
               K_EBREAK: m_mcause[k] = 64'd3;
               K_ILL:    m_mcause[k] = 64'd2;
               default:  m_mcause[k] = (k == 0) ? 64'h8000_000B : 64'h8000_0000_0000_000B;
            endcase
         end else if (we) begin
            case (addr)
               12'h300: begin m_mie[k] = wdata[3]; m_mpie[k] = wdata[7]; end
               12'h305: m_mtvec[k] = wdata & ~64'h3 & msk(k);
               12'h341: m_mepc[k] = wdata & ~64'h3 & msk(k);
               12'h342: m_mcause[k] = wdata & msk(k);
               default: ;
            endcase
         end
      end
   end

   task automatic cmp_inst(input int k, input logic kill, input logic ecall, input logic mret,
                           input logic redir, input logic busy, input logic [63:0] rpc,
                           input logic [63:0] rdata);
      int kind;
      string sfx;
      kind = classify(k);
      sfx  = (k == 0) ? "32" : "64";
      chk({"kill", sfx},  64'(kill),  64'(kind != K_NONE));
      chk({"ecall", sfx}, 64'(ecall), 64'(kind == K_ECALL));
      chk({"mret", sfx},  64'(mret),  64'(kind == K_MRET));
      chk({"redir", sfx}, 64'(redir), 64'(m_busy[k]));
      chk({"busy", sfx},  64'(busy),  64'(m_busy[k]));
      chk({"rdata", sfx}, rdata, csr_read(k));
      if (m_busy[k]) chk({"rpc", sfx}, rpc, m_target[k]);
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp_inst(0, a_kill, a_ecall, a_mret, a_redir, a_busy, 64'(a_rpc), 64'(a_rdata));
         cmp_inst(1, b_kill, b_ecall, b_mret, b_redir, b_busy, b_rpc, b_rdata);
      end
   end

   task automatic cyc(input logic r, input logic v, input logic e, input logic [2:0] fn3,
                      input logic [11:0] fn12, input logic [63:0] p, input logic q,
                      input logic w, input logic [11:0] ad, input logic [63:0] wd);
      @(posedge clk);
      #1;
      rst = r; valid = v; exc = e; f3 = fn3; f12 = fn12; pc = p; irq = q;
      we = w; addr = ad; wdata = wd;
      @(negedge clk);
   endtask

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h305, 0);
      chk("rst_redir", 64'(a_redir), 0);
      chk("rst_rpc", 64'(a_rpc), 0);
      chk("rst_mtvec32", 64'(a_rdata), 64'h80);
      chk("rst_mtvec64", b_rdata, 64'h1000);

      // ecall with mtvec = 0x200
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 12'h305, 64'h202);
      cyc(0, 1, 1, 0, 12'h000, 64'h100, 0, 0, 12'h305, 0);
      chk("t1_kill", 64'(a_kill), 1);
      chk("t1_ecall", 64'(b_ecall), 1);
      chk("t1_mtvec", 64'(a_rdata), 64'h200);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h342, 0);
      chk("t1_redir", 64'(a_redir), 1);
      chk("t1_rpc32", 64'(a_rpc), 64'h200);
      chk("t1_rpc64", b_rpc, 64'h200);
      chk("t1_mcause", b_rdata, 64'd11);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h341, 0);
      chk("t1_mepc", 64'(a_rdata), 64'h100);
      chk("t1_redir_off", 64'(a_redir), 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h300, 0);
      chk("t1_mstatus", 64'(a_rdata), 64'h1800);

      // MIE=1, ebreak, then mret
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 12'h300, 64'h8);
      cyc(0, 1, 1, 0, 12'h001, 64'h107, 0, 0, 12'h341, 0);
      chk("t2_kill", 64'(a_kill), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h341, 0);
      chk("t2_mepc", 64'(a_rdata), 64'h104);
      cyc(0, 1, 1, 0, 12'h302, 64'h500, 0, 0, 12'h300, 0);
      chk("t2_mret", 64'(a_mret), 1);
      chk("t2_mstat_pre", 64'(a_rdata), 64'h1880);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h300, 0);
      chk("t2_rpc", 64'(a_rpc), 64'h104);
      chk("t2_mstat_post", b_rdata, 64'h1888);

      // interrupt gating and priority
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 12'h300, 64'h0);
      cyc(0, 1, 0, 0, 0, 64'h300, 1, 0, 12'h342, 0);
      chk("t3_irq_masked", 64'(a_kill), 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 1, 12'h300, 64'h8);
      cyc(0, 1, 0, 0, 0, 64'h300, 1, 0, 12'h342, 0);
      chk("t3_irq_kill", 64'(a_kill), 1);
      chk("t3_irq_ecall", 64'(a_ecall), 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 12'h342, 0);
      chk("t3_cause32", 64'(a_rdata), 64'h8000_000B);
      chk("t3_cause64", b_rdata, 64'h8000_0000_0000_000B);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 12'h300, 64'h8);
      cyc(0, 1, 1, 0, 12'h000, 64'h10, 1, 0, 12'h342, 0);
      chk("t3_both_ecall", 64'(a_ecall), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h342, 0);
      chk("t3_both_cause", 64'(a_rdata), 64'd11);

      // illegal encodings and a non-trapping CSR op
      cyc(0, 1, 1, 0, 12'h105, 64'h20, 0, 0, 12'h342, 0);
      chk("t4_wfi_kill", 64'(a_kill), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h342, 0);
      chk("t4_wfi_cause", 64'(a_rdata), 64'd2);
      chk("t4_wfi_rpc", 64'(a_rpc), 64'h200);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 12'h342, 64'h0);
      cyc(0, 1, 1, 3'd4, 12'h000, 64'h24, 0, 0, 12'h342, 0);
      chk("t4_f3_kill", 64'(a_kill), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h342, 0);
      chk("t4_f3_cause", 64'(a_rdata), 64'd2);
      cyc(0, 1, 1, 3'd1, 12'h305, 64'h28, 0, 0, 12'h342, 0);
      chk("t4_csrop_kill", 64'(a_kill), 0);

      // CSR write colliding with a trap, and an event during REDIR
      cyc(0, 1, 1, 0, 12'h000, 64'h40, 0, 1, 12'h305, 64'h400);
      chk("t5_kill", 64'(a_kill), 1);
      cyc(0, 1, 1, 0, 12'h000, 64'h80, 0, 1, 12'h305, 64'h404);
      chk("t5_redir_kill", 64'(a_kill), 0);
      chk("t5_rpc", 64'(a_rpc), 64'h200);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h305, 0);
      chk("t5_mtvec", 64'(a_rdata), 64'h200);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h341, 0);
      chk("t5_mepc", b_rdata, 64'h40);

      // reset during REDIR
      cyc(0, 1, 1, 0, 12'h001, 64'h50, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 12'h000, 64'h54, 0, 0, 12'h305, 0);
      chk("t6_rst_kill", 64'(a_kill), 0);
      chk("t6_rst_ecall", 64'(b_ecall), 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h300, 0);
      chk("t6_redir", 64'(b_redir), 0);
      chk("t6_busy", 64'(a_busy), 0);
      chk("t6_rpc", b_rpc, 0);
      chk("t6_mstatus", 64'(a_rdata), 64'h1800);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 12'h305, 0);
      chk("t6_mtvec32", 64'(a_rdata), 64'h80);
      chk("t6_mtvec64", b_rdata, 64'h1000);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [2:0]  rf3;
         logic [11:0] rf12, rad;
         case ($urandom_range(0, 3))
            0:       rf3 = 3'd0;
            1:       rf3 = 3'd4;
            default: rf3 = 3'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0:       rf12 = 12'h000;
            1:       rf12 = 12'h001;
            2:       rf12 = 12'h302;
            3:       rf12 = 12'h105;
            default: rf12 = 12'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0:       rad = 12'h300;
            1:       rad = 12'h305;
            2:       rad = 12'h341;
            3:       rad = 12'h342;
            default: rad = 12'($urandom);
         endcase
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             rf3, rf12, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, rad, {$urandom, $urandom});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
